// File: rtl/i2s_pattern_gen.sv
// Multi-channel test-sample source for the I2S transmit path: table, ramp, LFSR or constant samples on a valid/ready stream.
// Optional build macro I2S_PATTERN_CHAN_TAG_EN replaces out_data[W-1:W-4] with the channel index.
module i2s_pattern_gen #(
    parameter int I2S_DATA_BIT_WIDTH = 24,
    parameter int CHANNELS = 2,
    parameter int DEPTH = 5,
    parameter int RAMP_STEP = 1,
    parameter logic [I2S_DATA_BIT_WIDTH-1:0] LFSR_TAPS = 24'hE10000,
    parameter logic [I2S_DATA_BIT_WIDTH-1:0] LFSR_SEED = 24'h000001,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2((CHANNELS > 2) ? CHANNELS : 2)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [I2S_DATA_BIT_WIDTH-1:0] const_value,
    input  logic                          tbl_wr_en,
    input  logic [AW-1:0]                 tbl_wr_addr,
    input  logic [I2S_DATA_BIT_WIDTH-1:0] tbl_wr_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [I2S_DATA_BIT_WIDTH-1:0] out_data,
    output logic [CW-1:0]                 out_chan,
    output logic                          out_last,
    output logic                          busy
);

    localparam int W = I2S_DATA_BIT_WIDTH;
    localparam logic [W-1:0] SEED = (LFSR_SEED == '0) ? W'(1) : LFSR_SEED;
    localparam logic [1:0] MODE_TABLE = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] chan_reg, chan_next;
    logic [AW-1:0] ptr_reg, ptr_next;
    logic [AW-1:0] frame_idx_reg, frame_idx_next;
    logic [W-1:0]  ramp_base_reg, ramp_base_next;
    logic [W-1:0]  lfsr_reg, lfsr_next;
    logic [1:0]    mode_reg, mode_next;
    logic          out_valid_reg, out_valid_next;
    logic [W-1:0]  out_data_reg, out_data_next;
    logic          out_last_reg, out_last_next;
    logic [W-1:0]  tbl_mem_reg [DEPTH];

    logic          transfer;
    logic          load;
    logic [CW-1:0] load_chan;
    logic [AW-1:0] load_ptr;
    logic [W-1:0]  pattern;

    assign transfer  = out_valid_reg && out_ready;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_chan  = chan_reg;
    assign out_last  = out_last_reg;
    assign busy      = out_valid_reg || (state_reg == RUN);

    always_comb begin
        state_next     = state_reg;
        chan_next      = chan_reg;
        ptr_next       = ptr_reg;
        frame_idx_next = frame_idx_reg;
        ramp_base_next = ramp_base_reg;
        lfsr_next      = lfsr_reg;
        mode_next      = mode_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        load           = 1'b0;
        load_chan      = '0;
        load_ptr       = ptr_reg;
        pattern        = '0;

        // The LFSR steps on every accepted LFSR beat so the following load sees the new state.
        if (transfer && (mode_reg == MODE_LFSR)) begin
            lfsr_next = {lfsr_reg[W-2:0], ^(lfsr_reg & LFSR_TAPS)};
        end

        case (state_reg)
            IDLE: begin
                if (en) begin
                    load       = 1'b1;
                    load_ptr   = frame_idx_reg;
                    mode_next  = mode;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (transfer) begin
                    if (out_last_reg) begin
                        frame_idx_next = (frame_idx_reg == AW'(DEPTH - 1)) ? '0 : frame_idx_reg + 1'b1;
                        ramp_base_next = ramp_base_reg + W'(RAMP_STEP);
                        if (en) begin
                            load      = 1'b1;
                            load_ptr  = frame_idx_next;
                            mode_next = mode;
                        end else begin
                            out_valid_next = 1'b0;
                            state_next     = IDLE;
                        end
                    end else begin
                        load      = 1'b1;
                        load_chan = chan_reg + 1'b1;
                        load_ptr  = (ptr_reg == AW'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        case (mode_next)
            MODE_TABLE: pattern = tbl_mem_reg[load_ptr];
            MODE_RAMP:  pattern = ramp_base_next + W'(load_chan);
            MODE_LFSR:  pattern = lfsr_next;
            default:    pattern = const_value;
        endcase

        if (load) begin
            out_valid_next = 1'b1;
            chan_next      = load_chan;
            ptr_next       = load_ptr;
            out_last_next  = (load_chan == CW'(CHANNELS - 1));
`ifdef I2S_PATTERN_CHAN_TAG_EN
            out_data_next  = {4'(load_chan), pattern[W-5:0]};
`else
            out_data_next  = pattern;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            chan_reg      <= '0;
            ptr_reg       <= '0;
            frame_idx_reg <= '0;
            ramp_base_reg <= '0;
            lfsr_reg      <= SEED;
            mode_reg      <= MODE_TABLE;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_mem_reg[i] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            chan_reg      <= chan_next;
            ptr_reg       <= ptr_next;
            frame_idx_reg <= frame_idx_next;
            ramp_base_reg <= ramp_base_next;
            lfsr_reg      <= lfsr_next;
            mode_reg      <= mode_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
            // A beat loaded on this same edge already read the old entry.
            if (tbl_wr_en && (int'(tbl_wr_addr) < DEPTH)) begin
                tbl_mem_reg[tbl_wr_addr] <= tbl_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_i2s_pattern_gen.sv
// Directed bench for i2s_pattern_gen: vector table for table/backpressure/boundary/ramp/constant, hand sequences for LFSR, reset and table-write collision.
module tb_i2s_pattern_gen;

    localparam int W  = 24;
    localparam int AW = 3;
    localparam int CW = 1;
`ifdef I2S_PATTERN_CHAN_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [W-1:0]  const_value = '0;
    logic          tbl_wr_en = 1'b0;
    logic [AW-1:0] tbl_wr_addr = '0;
    logic [W-1:0]  tbl_wr_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_chan;
    logic          out_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    i2s_pattern_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .const_value (const_value),
        .tbl_wr_en   (tbl_wr_en),
        .tbl_wr_addr (tbl_wr_addr),
        .tbl_wr_data (tbl_wr_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         en;
        logic [1:0]   mode;
        logic         ready;
        logic [W-1:0] cval;
        logic         valid;
        logic [W-1:0] data;
        logic         chan;
        logic         last;
        logic         busy;
    } vec_t;

    vec_t vecs [32];
    int   nv = 0;

    task automatic add(input logic v_en, input logic [1:0] v_mode, input logic v_ready, input logic [W-1:0] v_cval,
                       input logic e_valid, input logic [W-1:0] e_data, input logic e_chan, input logic e_last,
                       input logic e_busy);
        vecs[nv] = {v_en, v_mode, v_ready, v_cval, e_valid, e_data, e_chan, e_last, e_busy};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] tag(input logic [W-1:0] d, input logic [3:0] c);
        logic [W-1:0] r;
        r = d;
        r[W-1:W-4] = TAG_EN ? c : d[W-1:W-4];
        return r;
    endfunction

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
        return {s[W-2:0], ^(s & 24'hE10000)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic drain(input string name);
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!out_valid) break;
            tick();
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    logic [W-1:0] tbl_init [5];
    logic [W-1:0] lfsr_first [4];
    logic [W-1:0] model;
    logic [W-1:0] exp_d;
    int           entry;

    initial begin
        tbl_init[0] = 24'h123456; tbl_init[1] = 24'h345678; tbl_init[2] = 24'h567890;
        tbl_init[3] = 24'h789012; tbl_init[4] = 24'h901234;
        lfsr_first[0] = 24'h000001; lfsr_first[1] = 24'h000002;
        lfsr_first[2] = 24'h000004; lfsr_first[3] = 24'h000008;

        // Table mode, three frames, then backpressure, then mode/en change mid-frame.
        add(1'b1, 2'd0, 1'b1, 24'h0, 1'b1, 24'h123456, 1'b0, 1'b0, 1'b1);
        add(1'b1, 2'd0, 1'b1, 24'h0, 1'b1, 24'h345678, 1'b1, 1'b1, 1'b1);
        add(1'b1, 2'd0, 1'b1, 24'h0, 1'b1, 24'h345678, 1'b0, 1'b0, 1'b1);
        add(1'b1, 2'd0, 1'b1, 24'h0, 1'b1, 24'h567890, 1'b1, 1'b1, 1'b1);
        add(1'b1, 2'd0, 1'b1, 24'h0, 1'b1, 24'h567890, 1'b0, 1'b0, 1'b1);
        add(1'b1, 2'd0, 1'b1, 24'h0, 1'b1, 24'h789012, 1'b1, 1'b1, 1'b1);
        add(1'b1, 2'd0, 1'b1, 24'h0, 1'b1, 24'h789012, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            add(1'b1, 2'd0, 1'b0, 24'h0, 1'b1, 24'h789012, 1'b0, 1'b0, 1'b1);
        end
        add(1'b1, 2'd0, 1'b1, 24'h0, 1'b1, 24'h901234, 1'b1, 1'b1, 1'b1);
        add(1'b1, 2'd0, 1'b1, 24'h0, 1'b1, 24'h901234, 1'b0, 1'b0, 1'b1);
        add(1'b0, 2'd1, 1'b1, 24'h0, 1'b1, 24'h123456, 1'b1, 1'b1, 1'b1);
        add(1'b0, 2'd1, 1'b1, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2'd1, 1'b1, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        // Ramp base has advanced over five frame boundaries.
        add(1'b1, 2'd1, 1'b1, 24'h0, 1'b1, 24'h000005, 1'b0, 1'b0, 1'b1);
        add(1'b1, 2'd1, 1'b1, 24'h0, 1'b1, 24'h000006, 1'b1, 1'b1, 1'b1);
        add(1'b0, 2'd1, 1'b1, 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        // Constant mode samples const_value at each load.
        add(1'b1, 2'd3, 1'b1, 24'hABCDEF, 1'b1, 24'hABCDEF, 1'b0, 1'b0, 1'b1);
        add(1'b0, 2'd3, 1'b1, 24'h123ABC, 1'b1, 24'h123ABC, 1'b1, 1'b1, 1'b1);
        add(1'b0, 2'd3, 1'b1, 24'h123ABC, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);

        #2 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_chan", 32'(out_chan), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tbl_wr_en = 1'b1;
            tbl_wr_addr = AW'(i);
            tbl_wr_data = tbl_init[i];
            tick();
        end
        tbl_wr_en = 1'b0;
        chk("idle_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < nv; i++) begin
            en = vecs[i].en;
            mode = vecs[i].mode;
            out_ready = vecs[i].ready;
            const_value = vecs[i].cval;
            tick();
            $display("vec %0d en=%0d mode=%0d ready=%0d -> valid=%0d data=%h chan=%0d last=%0d busy=%0d",
                     i, en, mode, out_ready, out_valid, out_data, out_chan, out_last, busy);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tag(vecs[i].data, 4'(vecs[i].chan))));
                chk($sformatf("vec%0d_chan", i), 32'(out_chan), 32'(vecs[i].chan));
                chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(vecs[i].last));
            end
        end

        // LFSR from the reset seed, continuous across frames.
        reset_pulse();
        en = 1'b1;
        mode = 2'd2;
        out_ready = 1'b1;
        tick();
        model = 24'h000001;
        for (int k = 0; k < 28; k++) begin
            $display("lfsr beat %0d data=%h chan=%0d", k, out_data, out_chan);
            if (k < 4) begin
                chk($sformatf("lfsr_first%0d", k), 32'(out_data), 32'(tag(lfsr_first[k], 4'(k % 2))));
            end
            chk($sformatf("lfsr_beat%0d", k), 32'(out_data), 32'(tag(model, 4'(k % 2))));
            chk($sformatf("lfsr_chan%0d", k), 32'(out_chan), 32'(k % 2));
            model = lfsr_step(model);
            tick();
        end
        drain("lfsr_drain");

        // Asynchronous reset while channel 1 is presented.
        reset_pulse();
        en = 1'b1;
        mode = 2'd1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("pre_rst_chan", 32'(out_chan), 32'd1);
        #2 rst = 1'b0;
        #1;
        $display("async reset mid-frame: valid=%0d data=%h chan=%0d last=%0d busy=%0d",
                 out_valid, out_data, out_chan, out_last, busy);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_chan", 32'(out_chan), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'(tag(24'h0, 4'd0)));
        chk("post_rst_chan", 32'(out_chan), 32'd0);
        tick();
        chk("post_rst_data1", 32'(out_data), 32'(tag(24'h1, 4'd1)));
        drain("post_rst_drain");

        // Table write on the same edge as the first load: old value first, new value at the wrap.
        reset_pulse();
        en = 1'b1;
        mode = 2'd0;
        out_ready = 1'b1;
        tbl_wr_en = 1'b1;
        tbl_wr_addr = '0;
        tbl_wr_data = 24'h111111;
        tick();
        tbl_wr_en = 1'b0;
        for (int b = 0; b < 10; b++) begin
            entry = ((b / 2) + (b % 2)) % 5;
            exp_d = (b != 0 && entry == 0) ? 24'h111111 : 24'h0;
            $display("collision beat %0d data=%h chan=%0d last=%0d", b, out_data, out_chan, out_last);
            chk($sformatf("coll_beat%0d", b), 32'(out_data), 32'(tag(exp_d, 4'(b % 2))));
            tick();
        end
        drain("coll_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
